cfu_multicycle: RTL and testbench

Custom Function Unit with a selectable operation set and a stall-based handshake toward the CPU core. It supports single-cycle OR and accumulator operations plus iterative unsigned multiply, divide and remainder. It sits at the core's CFU slot: the core drives `en_i`, funct fields and operands, and holds the instruction while `stall_o` is high. Width and multiplier throughput are parameters.

---
 rtl/cfu_multicycle.sv | 170 +++++++++++++++++
 tb/tb_cfu_multicycle.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_multicycle.sv
// cfu_multicycle: custom function unit for the core's CFU slot.
// Single-cycle OR / accumulator ops answer combinationally. Unsigned multiply,
// divide and remainder run iteratively and stall the core until the result is ready.
module cfu_multicycle #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rslt_o
);

    localparam int MUL_ITER = XLEN / MUL_BITS;
    localparam int CW       = $clog2(XLEN);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_ITER - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(XLEN - 1);

    localparam logic [2:0] OP_OR      = 3'd0;
    localparam logic [2:0] OP_ACC_ADD = 3'd1;
    localparam logic [2:0] OP_ACC_CLR = 3'd2;
    localparam logic [2:0] OP_MULU    = 3'd3;
    localparam logic [2:0] OP_DIVU    = 3'd4;
    localparam logic [2:0] OP_REMU    = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;

    // a_q: multiplicand (shifts left) or dividend that becomes the quotient.
    // b_q: multiplier (shifts right) or divisor.
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] prod_q;
    logic [XLEN:0]   rem_q;

    logic            live_multi;
    logic            start;
    logic [XLEN-1:0] mul_part;
    logic [XLEN-1:0] prod_nxt;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    // funct7 is reserved and the remainder's top bit is always zero after a restore step.
    logic spare_unused;
    assign spare_unused = ^{funct7_i, rem_q[XLEN]};

    assign live_multi = (funct3_i == OP_MULU) || (funct3_i == OP_DIVU) || (funct3_i == OP_REMU);
    assign start      = en_i && live_multi && (state_q == IDLE);

    // One iteration of shift-add multiply and of restoring division.
    always_comb begin
        mul_part  = a_q * XLEN'(b_q[MUL_BITS-1:0]);
        prod_nxt  = prod_q + mul_part;
        div_shift = {rem_q[XLEN-1:0], a_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[XLEN];
        rem_nxt   = div_ge ? div_diff : div_shift;
        quo_nxt   = {a_q[XLEN-2:0], div_ge};
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the stall/result outputs.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        rslt_o  = '0;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (en_i && live_multi && (state_q != DONE)) begin
            stall_o = 1'b1;
        end
        if (en_i) begin
            case (funct3_i)
                OP_OR:      rslt_o = src1_i | src2_i;
                OP_ACC_ADD: rslt_o = acc_q + src1_i;
                OP_ACC_CLR: rslt_o = acc_q;
                OP_MULU, OP_DIVU, OP_REMU: begin
                    if (state_q == DONE) rslt_o = result_q;
                end
                default:    rslt_o = '0;
            endcase
        end
    end

    // Accumulator, updated by single-cycle ops at the end of their en_i cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (en_i) begin
            if (funct3_i == OP_ACC_ADD) begin
                acc_q <= acc_q + src1_i;
            end else if (funct3_i == OP_ACC_CLR) begin
                acc_q <= '0;
            end
        end
    end

    // Iterative datapath: latch on start, iterate in BUSY, capture the result on the last step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            op_q     <= OP_OR;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (start) begin
                a_q    <= src1_i;
                b_q    <= src2_i;
                prod_q <= '0;
                rem_q  <= '0;
                op_q   <= funct3_i;
                cnt_q  <= (funct3_i == OP_MULU) ? MUL_LOAD : DIV_LOAD;
            end else if (state_q == BUSY) begin
                if (op_q == OP_MULU) begin
                    prod_q <= prod_nxt;
                    a_q    <= a_q << MUL_BITS;
                    b_q    <= b_q >> MUL_BITS;
                end else begin
                    rem_q <= rem_nxt;
                    a_q   <= quo_nxt;
                end
                if (cnt_q == '0) begin
                    if (op_q == OP_MULU) begin
                        result_q <= prod_nxt;
                    end else if (op_q == OP_DIVU) begin
                        result_q <= quo_nxt;
                    end else begin
                        result_q <= rem_nxt[XLEN-1:0];
                    end
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cfu_multicycle.sv
// Self-checking bench for cfu_multicycle: directed table, multi-cycle corner
// sequences and random operations compared with an arithmetic reference model.
module tb_cfu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall;
    logic [31:0] rslt;
    logic        stall4;
    logic [31:0] rslt4;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_acc;

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    cfu_multicycle #(.XLEN(32), .MUL_BITS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .funct3_i(f3), .funct7_i(f7),
        .src1_i(src1), .src2_i(src2), .stall_o(stall), .rslt_o(rslt)
    );

    cfu_multicycle #(.XLEN(32), .MUL_BITS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .funct3_i(f3), .funct7_i(f7),
        .src1_i(src1), .src2_i(src2), .stall_o(stall4), .rslt_o(rslt4)
    );

    // Free-running clock, rising edge active.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] acc);
        logic [63:0] p;
        case (fn)
            3'd0: return a | b;
            3'd1: return acc + a;
            3'd2: return acc;
            3'd3: begin p = 64'(a) * 64'(b); return p[31:0]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_acc(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] acc);
        if (fn == 3'd1) return acc + a;
        if (fn == 3'd2) return 32'h0;
        return acc;
    endfunction

    function automatic bit is_multi(input logic [2:0] fn);
        return (fn == 3'd3) || (fn == 3'd4) || (fn == 3'd5);
    endfunction

    task automatic applyStimulus(input logic e, input logic [2:0] fn, input logic [31:0] a,
                                 input logic [31:0] b);
        en   = e;
        f3   = fn;
        f7   = 7'($urandom);
        src1 = a;
        src2 = b;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One-cycle instruction: result and no stall in the same cycle.
    task automatic single_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expected);
        @(negedge clk);
        applyStimulus(1'b1, fn, a, b);
        #1;
        checkOutput($sformatf("%s stall", name), {31'b0, stall}, 32'd0);
        checkOutput(name, rslt, expected);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    // Multi-cycle instruction held until stall drops; counts stall cycles.
    task automatic multi_op(input string name, input bit use4, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expected, input int exp_stalls);
        int stalls  = 0;
        bit done    = 1'b0;
        bit timeout = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, fn, a, b);
        while (!done) begin
            #1;
            if ((use4 ? stall4 : stall) == 1'b0) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (timeout) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got >200 stall cycles, expected %0d", name, exp_stalls);
        end else begin
            checkOutput(name, use4 ? rslt4 : rslt, expected);
            checkOutput($sformatf("%s stall cycles", name), 32'(stalls), 32'(exp_stalls));
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_val;
        logic        seen_out;

        vecs[0]  = '{3'd0, 32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0};
        vecs[1]  = '{3'd1, 32'h0000_0005, 32'h1234_5678, 32'h0000_0005};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0003};
        vecs[3]  = '{3'd2, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0003};
        vecs[4]  = '{3'd1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007};
        vecs[5]  = '{3'd6, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0000};
        vecs[6]  = '{3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{3'd3, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[9]  = '{3'd4, 32'd100,       32'd7,         32'd14};
        vecs[10] = '{3'd5, 32'd100,       32'd7,         32'd2};
        vecs[11] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{3'd5, 32'd5,         32'd0,         32'd5};

        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        rst_n     = 1'b0;
        model_acc = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset rslt", rslt, 32'h0);
        rst_n = 1'b1;

        @(negedge clk);
        applyStimulus(1'b0, 3'd3, 32'h0000_F0F0, 32'h0F0F_0000);
        #1;
        checkOutput("idle en low stall", {31'b0, stall}, 32'd0);
        checkOutput("idle en low rslt", rslt, 32'h0);

        for (int i = 0; i < 13; i++) begin
            if (is_multi(vecs[i].fn)) begin
                multi_op($sformatf("vec%0d", i), 1'b0, vecs[i].fn, vecs[i].a, vecs[i].b,
                         vecs[i].exp, 33);
            end else begin
                single_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);
                model_acc = ref_acc(vecs[i].fn, vecs[i].a, model_acc);
            end
        end

        // Reset clears the accumulator.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        model_acc = 32'h0;
        single_op("acc add after reset", 3'd1, 32'd1, 32'd0, 32'd1);
        model_acc = 32'd1;

        // Four multiplier bits per cycle shortens MULU to 8 iterations.
        multi_op("mulu x4", 1'b1, 3'd3, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 9);
        repeat (40) @(negedge clk);

        // en_i dropped mid-BUSY: outputs stay quiet and the unit recovers.
        @(negedge clk);
        applyStimulus(1'b1, 3'd4, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("drop: stall while busy", {31'b0, stall}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        seen_out = 1'b0;
        repeat (40) begin
            #1;
            if (stall || (rslt != 32'h0)) seen_out = 1'b1;
            @(negedge clk);
        end
        checkOutput("drop: outputs quiet", {31'b0, seen_out}, 32'd0);
        single_op("drop: or after", 3'd0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        multi_op("drop: mulu after", 1'b0, 3'd3, 32'd123, 32'd456, 32'd56088, 33);

        // Reset pulse in the middle of a DIVU.
        @(negedge clk);
        applyStimulus(1'b1, 3'd4, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset stall", {31'b0, stall}, 32'd0);
        checkOutput("mid reset rslt", rslt, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_acc = 32'h0;
        multi_op("divu 9/3 after reset", 1'b0, 3'd4, 32'd9, 32'd3, 32'd3, 33);
        single_op("acc clr after reset", 3'd2, 32'd0, 32'd0, 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            int sel;
            fn  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) b = 32'($urandom_range(1, 20));
            else if (sel == 2) a = 32'($urandom_range(0, 1000));
            exp_val = ref_result(fn, a, b, model_acc);
            if (is_multi(fn)) begin
                multi_op($sformatf("rand%0d f3=%0d", i, fn), 1'b0, fn, a, b, exp_val, 33);
            end else begin
                single_op($sformatf("rand%0d f3=%0d", i, fn), fn, a, b, exp_val);
                model_acc = ref_acc(fn, a, model_acc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
